animate_egg_multi: RTL
======================

Name: animate_egg_multi

Overview:
Parametrised successor to the single-egg animator. It moves up to NUM_EGGS falling eggs per animation step, one slot at a time. For each active egg it erases the old sprite, shifts it down by a speed value, checks whether it has landed (caught or missed), and redraws it. It sits between the game controller (spawn/go/speed/player position) and the VGA adapter, and drives the shared plot port as a single serialised pixel stream.

Parameters:
NUM_EGGS, 4, number of independent egg slots (1..8)
SCREEN_H, 120, visible screen height in pixels; landing line
EGG_W, 2, egg sprite width in pixels (1..8)
EGG_H, 2, egg sprite height in pixels (1..8)
PLYR_W, 20, player basket width; catch range is plyr_x..plyr_x+PLYR_W inclusive
SPEED_W, 3, width of speed input
EGG_COLOUR, 3'b111, draw colour (erase colour is always 3'b000)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  1  start one animation step; sampled only in IDLE
spawn_en  in  NUM_EGGS  per-slot spawn request; sampled only in IDLE
spawn_x  in  8*NUM_EGGS  spawn x for slot i at bits [8i+7:8i]
speed  in  SPEED_W  pixels added to y per step
plyr_x  in  8  player left x
vga_x  out  8  pixel x
vga_y  out  7  pixel y
colour  out  3  pixel colour
plot  out  1  pixel write enable
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle pulse at the end of a step
caught  out  1  one-cycle pulse per egg caught
missed  out  1  one-cycle pulse per egg missed
lose  out  1  sticky; cleared only by reset
active  out  NUM_EGGS  per-slot occupancy

Behaviour:
- Reset (async, resetn=0): FSM to IDLE; all slots inactive; x and y regs to 0; all outputs 0. Applies mid-step; no further pixels are emitted.
- IDLE: for each i with spawn_en[i]=1 and active[i]=0, on the next edge set active[i]=1, x[i]=spawn_x[i], y[i]=0. Spawn requests to an active slot are ignored. If go=1 in the same cycle, the spawn takes effect first and the step includes the new egg. When go=1, move to SELECT with slot index 0.
- SELECT (1 cycle): if active[idx]=1, go to ERASE. Otherwise go to NEXT logic: if idx<NUM_EGGS-1, increment idx and stay in SELECT; else go to DONE.
- ERASE (EGG_W*EGG_H cycles): plot=1, colour=000, at (x+dx, y+dy). Pixel order is row-major, dx fastest, starting at (0,0).
- SHIFT (1 cycle): y_new = y + speed, computed 8 bits wide with no 7-bit wrap.
- CHECK (1 cycle): landed when y_new+EGG_H >= SCREEN_H.
  - Landed and plyr_x <= x <= plyr_x+PLYR_W (9-bit sum): caught=1, active[idx]=0.
  - Landed, otherwise: missed=1, lose set, active[idx]=0.
  - Landed in either case: skip DRAW.
  - Not landed: store y=y_new[6:0], go to DRAW.
- DRAW (EGG_W*EGG_H cycles): plot=1, colour=EGG_COLOUR, same pixel order as ERASE, at the new y. Then NEXT logic.
- DONE (1 cycle): done=1, then IDLE.
- plot=0 outside ERASE and DRAW. vga_x/vga_y/colour hold their last value when plot=0.
- Step latency: NUM_EGGS SELECT cycles + per-active-egg (2P+2, or P+2 if landed) + 1 DONE cycle, where P=EGG_W*EGG_H. busy is high for exactly that many cycles.
- speed=0: the egg is erased and redrawn in place; it never lands unless already at the landing line.
- A spawn_x with x+EGG_W>160 is accepted; the VGA adapter clips. No check is made here.

Optional Feature:
Macro ANIMATE_EGG_MULTI_LIVES_EN.
- Defined: a 2-bit lives counter resets to 3. Each miss decrements it, saturating at 0. lose is set only when a miss brings it to 0. An extra output lives [1:0] is added.
- Not defined: no counter, no lives port; lose is set on the first miss.
- missed pulses identically in both builds.

Test Plan:
- Reset mid-DRAW (assert resetn=0 during pixel 2) -> plot=0, busy=0, active=0000 immediately; no pixel afterwards.
- Spawn slot0 x=50, go, speed=3, 2x2 egg -> erase (50..51, 0..1) colour 000, draw (50..51, 3..4) colour 111; busy 15 cycles; done pulse once.
- Slot0 at y=115, x=60, plyr_x=50, speed=5 -> caught pulse, active[0]=0, no DRAW pixels, lose=0.
- Slot1 at y=117, x=10, plyr_x=50, speed=2 -> missed pulse, lose=1 and stays 1 after further steps. With LIVES_EN: lives 3->2, lose=0; after 3 misses lose=1.
- Slots 0 and 2 active, slot0 landing -> slot0 processed in P+2 cycles, slot2 in 2P+2; caught pulse before slot2's pixels.
- spawn_en=0001 while slot0 already active with go=0 -> x/y of slot0 unchanged. go while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/animate_egg_multi.sv
// animate_egg_multi: moves up to NUM_EGGS falling eggs per animation step,
// one slot at a time, and serialises all erase/redraw pixels onto a single
// plot port for the VGA adapter.
//
// Optional build macro: ANIMATE_EGG_MULTI_LIVES_EN adds a 2-bit lives counter
// (reset value 3) and a lives output; lose is then set only when a miss takes
// lives to 0. Without it, lose is set on the first miss.
//
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   go                 start one animation step (sampled in IDLE)
//   spawn_en, spawn_x  per-slot spawn request and x (slot i at [8i+7:8i])
//   speed              pixels added to y per step
//   plyr_x             player basket left x
//   vga_x, vga_y       pixel coordinate (held while plot=0)
//   colour, plot       pixel colour and write enable
//   busy, done         step in progress / one-cycle end-of-step pulse
//   caught, missed     one-cycle pulse per landed egg
//   lose               sticky loss flag
//   active             per-slot occupancy
//   lives              remaining lives (LIVES_EN build only)
module animate_egg_multi #(
    parameter int unsigned NUM_EGGS   = 4,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned EGG_W      = 2,
    parameter int unsigned EGG_H      = 2,
    parameter int unsigned PLYR_W     = 20,
    parameter int unsigned SPEED_W    = 3,
    parameter logic [2:0]  EGG_COLOUR = 3'b111
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  go,
    input  logic [NUM_EGGS-1:0]   spawn_en,
    input  logic [8*NUM_EGGS-1:0] spawn_x,
    input  logic [SPEED_W-1:0]    speed,
    input  logic [7:0]            plyr_x,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [2:0]            colour,
    output logic                  plot,
    output logic                  busy,
    output logic                  done,
    output logic                  caught,
    output logic                  missed,
    output logic                  lose,
    output logic [NUM_EGGS-1:0]   active
`ifdef ANIMATE_EGG_MULTI_LIVES_EN
    ,
    output logic [1:0]            lives
`endif
);

    localparam int unsigned IDX_W = (NUM_EGGS > 1) ? $clog2(NUM_EGGS) : 1;
    localparam int unsigned DX_W  = (EGG_W > 1) ? $clog2(EGG_W) : 1;
    localparam int unsigned DY_W  = (EGG_H > 1) ? $clog2(EGG_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ERASE,
        S_SHIFT,
        S_CHECK,
        S_DRAW,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [DX_W-1:0]  dx_q;
    logic [DY_W-1:0]  dy_q;
    logic [7:0]       y_new_q;
    logic [7:0]       x_q [NUM_EGGS];
    logic [6:0]       y_q [NUM_EGGS];

    logic [7:0]       cur_x;
    logic [6:0]       cur_y;
    logic [DX_W-1:0]  dx_nxt;
    logic [DY_W-1:0]  dy_nxt;
    logic             last_pix;
    logic             last_idx;
    logic             landed;
    logic             in_range;

    // Current-slot lookup, sprite pixel walk (row-major, dx fastest) and landing tests
    always_comb begin
        cur_x    = x_q[idx_q];
        cur_y    = y_q[idx_q];
        dx_nxt   = dx_q + DX_W'(1);
        dy_nxt   = dy_q;
        if (dx_q == DX_W'(EGG_W - 1)) begin
            dx_nxt = '0;
            dy_nxt = dy_q + DY_W'(1);
        end
        last_pix = (dx_q == DX_W'(EGG_W - 1)) && (dy_q == DY_W'(EGG_H - 1));
        last_idx = (idx_q == IDX_W'(NUM_EGGS - 1));
        landed   = (9'(y_new_q) + 9'(EGG_H)) >= 9'(SCREEN_H);
        in_range = (cur_x >= plyr_x) && (9'(cur_x) <= (9'(plyr_x) + 9'(PLYR_W)));
    end

    // Step sequencer with registered outputs; every output changes with the state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            y_new_q <= '0;
            for (int i = 0; i < NUM_EGGS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            vga_x   <= '0;
            vga_y   <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            caught  <= 1'b0;
            missed  <= 1'b0;
            lose    <= 1'b0;
            active  <= '0;
`ifdef ANIMATE_EGG_MULTI_LIVES_EN
            lives   <= 2'd3;
`endif
        end else begin
            done   <= 1'b0;
            caught <= 1'b0;
            missed <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Spawns land before a same-cycle go, so the step sees new eggs
                    for (int i = 0; i < NUM_EGGS; i++) begin
                        if (spawn_en[i] && !active[i]) begin
                            active[i] <= 1'b1;
                            x_q[i]    <= spawn_x[8*i +: 8];
                            y_q[i]    <= '0;
                        end
                    end
                    if (go) begin
                        state <= S_SELECT;
                        idx_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (active[idx_q]) begin
                        state  <= S_ERASE;
                        dx_q   <= '0;
                        dy_q   <= '0;
                        plot   <= 1'b1;
                        colour <= 3'b000;
                        vga_x  <= cur_x;
                        vga_y  <= cur_y;
                    end else if (!last_idx) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (last_pix) begin
                        plot  <= 1'b0;
                        state <= S_SHIFT;
                    end else begin
                        dx_q  <= dx_nxt;
                        dy_q  <= dy_nxt;
                        vga_x <= cur_x + 8'(dx_nxt);
                        vga_y <= cur_y + 7'(dy_nxt);
                    end
                end
                S_SHIFT: begin
                    // 8-bit sum so an egg near the bottom cannot wrap back to the top
                    y_new_q <= 8'(cur_y) + 8'(speed);
                    state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (landed) begin
                        active[idx_q] <= 1'b0;
                        if (in_range) begin
                            caught <= 1'b1;
                        end else begin
                            missed <= 1'b1;
`ifdef ANIMATE_EGG_MULTI_LIVES_EN
                            if (lives != 2'd0) begin
                                lives <= lives - 2'd1;
                            end
                            if (lives == 2'd1) begin
                                lose <= 1'b1;
                            end
`else
                            lose <= 1'b1;
`endif
                        end
                        if (!last_idx) begin
                            idx_q <= idx_q + IDX_W'(1);
                            state <= S_SELECT;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        y_q[idx_q] <= y_new_q[6:0];
                        state      <= S_DRAW;
                        dx_q       <= '0;
                        dy_q       <= '0;
                        plot       <= 1'b1;
                        colour     <= EGG_COLOUR;
                        vga_x      <= cur_x;
                        vga_y      <= y_new_q[6:0];
                    end
                end
                S_DRAW: begin
                    if (last_pix) begin
                        plot <= 1'b0;
                        if (!last_idx) begin
                            idx_q <= idx_q + IDX_W'(1);
                            state <= S_SELECT;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        dx_q  <= dx_nxt;
                        dy_q  <= dy_nxt;
                        vga_x <= cur_x + 8'(dx_nxt);
                        vga_y <= cur_y + 7'(dy_nxt);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule
